// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Optional macro DIV_EARLY_OUT_EN sends divide-by-zero and signed overflow straight to DONE.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       func3_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] force_q, force_d, result_q, result_d;
  logic [2:0]       func_q, func_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, special_q, special_d;

  // Operand decode, only meaningful in the accepting IDLE cycle
  logic             is_div_in, a_signed_in, b_signed_in, sa_in, sb_in;
  logic             div0_in, ovf_in, special_in, accept;
  logic [WIDTH-1:0] ma_in, mb_in, force_in;

  always_comb begin
    is_div_in   = func3_i[2];
    a_signed_in = is_div_in ? ~func3_i[0] : (func3_i[1:0] == 2'b01 || func3_i[1:0] == 2'b10);
    b_signed_in = is_div_in ? ~func3_i[0] : (func3_i[1:0] == 2'b01);
    sa_in       = a_signed_in & op_a_i[WIDTH-1];
    sb_in       = b_signed_in & op_b_i[WIDTH-1];
    ma_in       = sa_in ? -op_a_i : op_a_i;
    mb_in       = sb_in ? -op_b_i : op_b_i;
    div0_in     = (op_b_i == '0);
    ovf_in      = ~func3_i[0] && (op_a_i == MIN_NEG) && (op_b_i == '1);
    special_in  = is_div_in & (div0_in | ovf_in);
    // func3[1] distinguishes REM/REMU from DIV/DIVU
    force_in    = div0_in ? (func3_i[1] ? op_a_i : '1) : (func3_i[1] ? '0 : MIN_NEG);
    accept      = start_i & ~kill_i;
  end

  // One iteration step
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge, is_div;
  logic [WIDTH-1:0] step_hi, step_lo, quot_s, rem_s, final_res;
  logic [2*WIDTH-1:0] prod, prod_s;

  always_comb begin
    is_div   = func_q[2];
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_ge   = ~div_diff[WIDTH];
    step_hi  = is_div ? (div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
    step_lo  = is_div ? {lo_q[WIDTH-2:0], div_ge} : {mul_sum[0], lo_q[WIDTH-1:1]};
    prod     = {step_hi, step_lo};
    prod_s   = neg_q ? -prod : prod;
    quot_s   = neg_q ? -step_lo : step_lo;
    rem_s    = rneg_q ? -step_hi : step_hi;
    if (special_q)            final_res = force_q;
    else if (is_div)          final_res = func_q[1] ? rem_s : quot_s;
    else if (func_q == 3'b000) final_res = prod_s[WIDTH-1:0];
    else                      final_res = prod_s[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) begin
`ifdef DIV_EARLY_OUT_EN
        state_d = special_in ? DONE : BUSY;
`else
        state_d = BUSY;
`endif
      end
      BUSY: if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  // Datapath next values
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    force_d   = force_q;
    func_d    = func_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    special_d = special_q;
    result_d  = result_q;
    if (state_q == IDLE && accept) begin
      cnt_d     = '0;
      hi_d      = '0;
      lo_d      = is_div_in ? ma_in : mb_in;
      opnd_d    = is_div_in ? mb_in : ma_in;
      force_d   = force_in;
      func_d    = func3_i;
      neg_d     = sa_in ^ sb_in;
      rneg_d    = sa_in;
      special_d = special_in;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 1'b1;
      hi_d  = step_hi;
      lo_d  = step_lo;
    end
    if (state_d == DONE && state_q != DONE)
      result_d = (state_q == IDLE) ? force_in : final_res;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      force_q   <= '0;
      func_q    <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      force_q   <= force_d;
      func_q    <= func_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  // Outputs
  always_comb begin
    busy_o   = (state_q != IDLE);
    valid_o  = (state_q == DONE);
    result_o = result_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table plus kill, reset and ignored-start sequences.
// Honours DIV_EARLY_OUT_EN for the expected latency of special divide cases.
module tb_muldiv_seq;

  localparam int FULL_LAT = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif
  localparam int NV = 21;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, kill_i, busy_o, valid_o;
  logic [2:0]  func3_i;
  logic [31:0] op_a_i, op_b_i, result_o;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] last_res;

  always #5 clk_i = ~clk_i;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .func3_i(func3_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
  );

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          special;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drives start in the current cycle; returns in cycle 1 of the operation.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    func3_i = f; op_a_i = a; op_b_i = b; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Called in cycle 1; returns in the valid cycle (or after the budget expires).
  task automatic wait_done(input string name, input int exp_lat, input logic [31:0] exp_res);
    int cyc = 1;
    logic busy_ok = 1'b1;
    while (cyc <= 100) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (valid_o === 1'b1) break;
      step();
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    check({name, " busy"}, {31'b0, busy_ok}, 32'd1);
    check({name, " result"}, result_o, exp_res);
  endtask

  initial begin
    vecs[0]  = '{"mul_ff_x2",      3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0};
    vecs[1]  = '{"mul_3x5",        3'b000, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0};
    vecs[2]  = '{"mul_min_xm1",    3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[3]  = '{"mulh_m1_m1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[4]  = '{"mulhu_ff_ff",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[5]  = '{"mulhsu_ff_ff",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{"mulh_min_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[7]  = '{"mulh_m2_x3",     3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{"div_m7_2",       3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{"rem_m7_2",       3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{"divu_100_7",     3'b101, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[11] = '{"remu_100_7",     3'b111, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[12] = '{"div_7_m2",       3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[13] = '{"rem_7_m2",       3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[14] = '{"divu_ff_1",      3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0};
    vecs[15] = '{"div_ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[16] = '{"rem_ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[17] = '{"remu_5_0",       3'b111, 32'd5,         32'd0,         32'd5,         1'b1};
    vecs[18] = '{"div_5_0",        3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[19] = '{"divu_7_0",       3'b101, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[20] = '{"rem_m5_0",       3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1};

    rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    func3_i = '0; op_a_i = '0; op_b_i = '0;
    step(); step();
    rst_i = 1'b0;
    check("reset busy", {31'b0, busy_o}, 32'd0);
    check("reset valid", {31'b0, valid_o}, 32'd0);
    check("reset result", result_o, 32'd0);

    // Each launch lands in the IDLE cycle right after the previous DONE.
    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, vecs[i].special ? EARLY_LAT : FULL_LAT, vecs[i].res);
      step();
      check({vecs[i].name, " done_len"}, {30'b0, busy_o, valid_o}, 32'd0);
      check({vecs[i].name, " held"}, result_o, vecs[i].res);
    end
    last_res = vecs[NV-1].res;

    // Start pulses while busy are ignored.
    begin
      launch(3'b000, 32'd3, 32'd5);
      repeat (4) step();
      func3_i = 3'b101; op_a_i = 32'd100; op_b_i = 32'd7; start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (10) step();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      repeat (14) step();  // now in cycle 31
      begin
        int lat = 31;
        while (lat <= 100 && valid_o !== 1'b1) begin step(); lat++; end
        check("ign_start latency", 32'(lat), 32'd33);
      end
      check("ign_start result", result_o, 32'd15);
      step();
      check("ign_start idle", {31'b0, busy_o}, 32'd0);
      last_res = 32'd15;
    end

    // Kill in cycle 10 of a DIV, with a competing start in the same cycle.
    begin
      logic saw_valid = 1'b0;
      launch(3'b100, 32'hFFFF_FFF9, 32'd2);
      for (int c = 1; c < 10; c++) begin
        if (valid_o === 1'b1) saw_valid = 1'b1;
        step();
      end
      kill_i = 1'b1; start_i = 1'b1;
      step();
      kill_i = 1'b0; start_i = 1'b0;
      if (valid_o === 1'b1) saw_valid = 1'b1;
      check("kill busy", {31'b0, busy_o}, 32'd0);
      check("kill no_valid", {31'b0, saw_valid}, 32'd0);
      check("kill result", result_o, last_res);
      step();
      launch(3'b111, 32'd100, 32'd7);
      wait_done("after_kill", FULL_LAT, 32'd2);
      step();
    end

    // Synchronous reset in cycle 5 of a MUL with start held high.
    begin
      logic saw_valid = 1'b0;
      launch(3'b000, 32'hFFFF_FFFF, 32'd2);
      repeat (4) step();
      rst_i = 1'b1; start_i = 1'b1;
      step();
      check("rst busy", {31'b0, busy_o}, 32'd0);
      check("rst valid", {31'b0, valid_o}, 32'd0);
      check("rst result", result_o, 32'd0);
      step(); step();
      check("rst hold busy", {31'b0, busy_o}, 32'd0);
      rst_i = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (valid_o === 1'b1) saw_valid = 1'b1;
        if (c == 0) begin
          step();
          start_i = 1'b0;
          check("rst release accept", {31'b0, busy_o}, 32'd1);
        end else begin
          step();
        end
      end
      check("rst release valid_seen", {31'b0, saw_valid}, 32'd1);
      check("rst release result", result_o, 32'hFFFF_FFFE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
